// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and its controller.
package mdu_pkg;

    localparam int MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mduOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mduState_e;

endpackage

// File: rtl/mult_div_unit_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on {acc, mq}.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] accNext,
    output logic [WIDTH-1:0] mqNext
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem;

    assign sum     = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
    assign shifted = {acc, mq[WIDTH-1]};
    assign fits    = shifted >= {1'b0, operand};
    // Remainder stays below the divisor, so the low WIDTH bits suffice.
    assign rem     = shifted[WIDTH-1:0] - operand;

    always_comb begin
        accNext = acc;
        mqNext  = mq;
        if (isDiv) begin
            accNext = fits ? rem : shifted[WIDTH-1:0];
            mqNext  = {mq[WIDTH-2:0], fits};
        end else begin
            accNext = sum[WIDTH:1];
            mqNext  = {sum[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit with start/busy/done handshake.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mduState_e state, stateNext;
    mduOp_e    opSel;

    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] acc, mq, operand;
    logic [WIDTH-1:0] accStep, mqStep;
    logic             isDiv, negQ, negR, divZero;

    logic isMulDiv, isSigned, isDivOp, isMthi, isMtlo;
    logic negA, negB, lastStep;
    logic [WIDTH-1:0]   absA, absB;
    logic [2*WIDTH-1:0] prod, prodFix;

    assign opSel = mduOp_e'(op);

    always_comb begin
        isMulDiv = 1'b0;
        isSigned = 1'b0;
        isDivOp  = 1'b0;
        isMthi   = 1'b0;
        isMtlo   = 1'b0;
        unique case (opSel)
            MDU_MULT:  begin isMulDiv = 1'b1; isSigned = 1'b1; end
            MDU_MULTU: isMulDiv = 1'b1;
            MDU_DIV: begin
                isMulDiv = 1'b1;
                isSigned = 1'b1;
                isDivOp  = 1'b1;
            end
            MDU_DIVU:  begin isMulDiv = 1'b1; isDivOp = 1'b1; end
            MDU_MTHI:  isMthi = 1'b1;
            MDU_MTLO:  isMtlo = 1'b1;
            default: ;
        endcase
    end

    assign negA = isSigned & srcA[WIDTH-1];
    assign negB = isSigned & srcB[WIDTH-1];
    assign absA = negA ? -srcA : srcA;
    assign absB = negB ? -srcB : srcB;

    assign lastStep = counter == CW'(WIDTH - 1);
    assign busy     = state != IDLE;

    assign prod    = {acc, mq};
    assign prodFix = negQ ? -prod : prod;

    mdu_iter_step #(.WIDTH(WIDTH)) uStep (
        .isDiv   (isDiv),
        .acc     (acc),
        .mq      (mq),
        .operand (operand),
        .accNext (accStep),
        .mqNext  (mqStep)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (start && isMulDiv) stateNext = RUN;
            RUN:  if (lastStep) stateNext = FIX;
            FIX:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            acc     <= '0;
            mq      <= '0;
            operand <= '0;
            isDiv   <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && isMulDiv) begin
                        counter <= '0;
                        acc     <= '0;
                        mq      <= isDivOp ? absA : absB;
                        operand <= isDivOp ? absB : absA;
                        isDiv   <= isDivOp;
                        negQ    <= negA ^ negB;
                        negR    <= isDivOp & negA;
                        divZero <= isDivOp && (srcB == '0);
                    end else if (start && isMthi) begin
                        hi <= srcA;
                    end else if (start && isMtlo) begin
                        lo <= srcA;
                    end
                end
                RUN: begin
                    acc     <= accStep;
                    mq      <= mqStep;
                    counter <= counter + CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (isDiv) begin
                        // Zero divisor leaves the dividend in acc.
                        hi <= negR ? -acc : acc;
                        lo <= divZero ? '1 : (negQ ? -mq : mq);
                    end else begin
                        hi <= prodFix[2*WIDTH-1:WIDTH];
                        lo <= prodFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
